// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async FIFO read-side packer.
// Holds the default widths and the lane keep-mask builder.
package async_fifo_pkg;

  localparam int DSIZE_DEF   = 8;
  localparam int PACK_DEF    = 4;
  localparam int TIMEOUT_DEF = 15;
  localparam int PACK_MAX    = 16;

  // Mask with the low n lanes set; n may be anything from 0 up to PACK_MAX.
  function automatic logic [PACK_MAX-1:0] keepMask(input int unsigned n);
    logic [PACK_MAX:0] one;
    one = (PACK_MAX+1)'(1) << n;
    return PACK_MAX'(one - 1'b1);
  endfunction

endpackage

// File: rtl/async_fifo_rd_packer_out_reg.sv
// One-entry valid/ready holding register for a packed beat.
// A load always wins; otherwise a handshake empties the slot.
module packer_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [KW-1:0] keep_o,
  output logic          last_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;
  logic          last_q, last_d;

  // Payload only changes on a load, so it holds while the consumer stalls.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      keep_d  = keep_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/async_fifo_rd_packer.sv
// Read-domain packer: pops FIFO words into PACK-lane beats and hands them to a
// valid/ready stream, closing partial beats on flush or idle timeout.
module async_fifo_rd_packer
  import async_fifo_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int PACK    = PACK_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_last
);

  localparam int CW = $clog2(PACK + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntFull  = CW'(PACK);
  localparam logic [IW-1:0] IdleFire = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '1;
  // Parking the idle count at the fire value keeps a blocked timeout asserted.
  localparam logic [IW-1:0] IdleSat  = (TIMEOUT > 0) ? IdleFire : '1;

  logic [PACK-1:0][DSIZE-1:0] lanes_q, lanes_d, beat;
  logic [CW-1:0]              cnt_q, cnt_d, cntNext;
  logic [IW-1:0]              idle_q, idle_d;
  logic                       pendFlush_q, pendFlush_d;
  logic                       pop, flushReq, timeoutFire, closeBeat, xfer;
  logic [PACK-1:0]            keepNext;

  // Pop decision and the view of the accumulator after this cycle's pop.
  always_comb begin
    pop  = rrst_n && !rempty && (cnt_q < CntFull);
    beat = lanes_q;
    for (int i = 0; i < PACK; i++) begin
      if (pop && (cnt_q == CW'(i))) begin
        beat[i] = rdata;
      end
    end
    cntNext     = cnt_q + CW'(pop);
    keepNext    = PACK'(keepMask(32'(cntNext)));
    flushReq    = flush || pendFlush_q;
    timeoutFire = (TIMEOUT > 0) && !pop && (cnt_q != '0) && (idle_q == IdleFire);
    closeBeat   = (cntNext == CntFull) || (flushReq && (cntNext != '0)) || timeoutFire;
    xfer        = closeBeat && (!out_valid || out_ready);
  end

  // A beat that moves out empties the accumulator; otherwise it keeps filling.
  always_comb begin
    cnt_d       = cntNext;
    lanes_d     = beat;
    pendFlush_d = pendFlush_q;
    idle_d      = idle_q;
    if (xfer) begin
      cnt_d       = '0;
      lanes_d     = '0;
      pendFlush_d = 1'b0;
      idle_d      = '0;
    end else begin
      if (flush && (cntNext != '0)) begin
        pendFlush_d = 1'b1;
      end
      if (pop) begin
        idle_d = '0;
      end else if ((cnt_q != '0) && (idle_q != IdleSat)) begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      lanes_q     <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      pendFlush_q <= 1'b0;
    end else begin
      lanes_q     <= lanes_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      pendFlush_q <= pendFlush_d;
    end
  end

  assign rinc = pop;

  // Any beat closed while a flush is requested is marked last.
  packer_out_reg #(
    .DW(DSIZE * PACK),
    .KW(PACK)
  ) u_outReg (
    .clk_i   (rclk),
    .rst_n_i (rrst_n),
    .load_i  (xfer),
    .data_i  (beat),
    .keep_i  (keepNext),
    .last_i  (flushReq),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .keep_o  (out_keep),
    .last_o  (out_last)
  );

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Randomized bench for async_fifo_rd_packer against a queue-based beat model,
// plus directed scenarios with hand-computed beats.
module tb_async_fifo_rd_packer;

  localparam int DSIZE   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 15;

  logic                  rclk = 1'b0;
  logic                  rrst_n = 1'b0;
  logic                  rempty = 1'b1;
  logic [DSIZE-1:0]      rdata = '0;
  logic                  rinc;
  logic                  flush = 1'b0;
  logic                  out_ready = 1'b0;
  logic                  out_valid;
  logic [DSIZE*PACK-1:0] out_data;
  logic [PACK-1:0]       out_keep;
  logic                  out_last;

  async_fifo_rd_packer #(
    .DSIZE(DSIZE),
    .PACK(PACK),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  always #5 rclk = ~rclk;

  int nChecks = 0;
  int nPass   = 0;

  logic [DSIZE-1:0]      fifoQ[$];
  logic [DSIZE-1:0]      accQ[$];
  bit                    mPend;
  int                    mIdle;
  bit                    mValid;
  logic [DSIZE*PACK-1:0] mData;
  logic [PACK-1:0]       mKeep;
  bit                    mLast;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic modelReset();
    accQ.delete();
    mPend  = 0;
    mIdle  = 0;
    mValid = 0;
    mData  = '0;
    mKeep  = '0;
    mLast  = 0;
  endtask

  // Drives one cycle of inputs, checks the DUT against the model, then steps the model.
  task automatic applyStimulus(input bit stall, input bit fl, input bit rdy);
    bit empty, pop, flushReq, closeNow;
    int n;
    empty     = stall || (fifoQ.size() == 0);
    rempty    = empty;
    rdata     = (fifoQ.size() > 0) ? fifoQ[0] : DSIZE'($urandom);
    flush     = fl;
    out_ready = rdy;
    #2;
    pop = !empty && (accQ.size() < PACK);
    checkOutput("rinc", 64'(rinc), 64'(pop));
    checkOutput("out_valid", 64'(out_valid), 64'(mValid));
    if (mValid) begin
      checkOutput("out_data", 64'(out_data), 64'(mData));
      checkOutput("out_keep", 64'(out_keep), 64'(mKeep));
      checkOutput("out_last", 64'(out_last), 64'(mLast));
    end
    if (pop) accQ.push_back(fifoQ.pop_front());
    n        = accQ.size();
    flushReq = fl || mPend;
    closeNow = (n == PACK) || (flushReq && n > 0) ||
               (TIMEOUT > 0 && !pop && n > 0 && mIdle >= TIMEOUT - 1);
    if (closeNow && (!mValid || rdy)) begin
      mValid = 1;
      mData  = '0;
      foreach (accQ[i]) mData[i*DSIZE +: DSIZE] = accQ[i];
      mKeep  = PACK'((1 << n) - 1);
      mLast  = flushReq;
      accQ.delete();
      mPend  = 0;
      mIdle  = 0;
    end else begin
      if (rdy) mValid = 0;
      if (fl && n > 0) mPend = 1;
      if (pop) mIdle = 0;
      else if (n > 0) mIdle++;
    end
    @(negedge rclk);
  endtask

  task automatic doReset();
    rrst_n = 1'b0;
    rempty = 1'b0;
    rdata  = DSIZE'($urandom);
    flush  = 1'b0;
    #2;
    checkOutput("rst_rinc", 64'(rinc), 64'(0));
    checkOutput("rst_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_data", 64'(out_data), 64'(0));
    checkOutput("rst_keep", 64'(out_keep), 64'(0));
    checkOutput("rst_last", 64'(out_last), 64'(0));
    modelReset();
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    @(negedge rclk);
    doReset();

    // Full beat of four words with the consumer always ready.
    fifoQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (4) applyStimulus(0, 0, 1);
    #1;
    checkOutput("tp_full_valid", 64'(out_valid), 64'(1));
    checkOutput("tp_full_data", 64'(out_data), 64'(32'h44332211));
    checkOutput("tp_full_keep", 64'(out_keep), 64'(4'b1111));
    checkOutput("tp_full_last", 64'(out_last), 64'(0));

    // Two words then a flush pulse.
    fifoQ = '{8'h11, 8'h22};
    repeat (2) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    #1;
    checkOutput("tp_flush_data", 64'(out_data), 64'(32'h00002211));
    checkOutput("tp_flush_keep", 64'(out_keep), 64'(4'b0011));
    checkOutput("tp_flush_last", 64'(out_last), 64'(1));

    // Three words then silence until the idle timeout closes the beat.
    fifoQ = '{8'hA1, 8'hB2, 8'hC3};
    repeat (3) applyStimulus(0, 0, 1);
    repeat (15) applyStimulus(0, 0, 1);
    #1;
    checkOutput("tp_tmo_valid", 64'(out_valid), 64'(1));
    checkOutput("tp_tmo_keep", 64'(out_keep), 64'(4'b0111));
    checkOutput("tp_tmo_last", 64'(out_last), 64'(0));
    checkOutput("tp_tmo_data", 64'(out_data), 64'(32'h00C3B2A1));

    // Backpressure: twelve words, consumer stalled, then released.
    applyStimulus(1, 0, 1);
    for (int i = 0; i < 12; i++) fifoQ.push_back(DSIZE'(8'h40 + i));
    repeat (10) applyStimulus(0, 0, 0);
    #1;
    checkOutput("tp_bp_rinc", 64'(rinc), 64'(0));
    checkOutput("tp_bp_left", 64'(fifoQ.size()), 64'(4));
    repeat (8) applyStimulus(0, 0, 1);
    checkOutput("tp_bp_drained", 64'(fifoQ.size()), 64'(0));

    // Pop coinciding with a flush on the fourth word.
    fifoQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    #1;
    checkOutput("tp_popfl_keep", 64'(out_keep), 64'(4'b1111));
    checkOutput("tp_popfl_last", 64'(out_last), 64'(1));

    // Reset with a partial accumulator and a held beat, then restart at lane 0.
    fifoQ = '{8'h55, 8'h66};
    repeat (2) applyStimulus(0, 0, 0);
    doReset();
    fifoQ.delete();
    fifoQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (4) applyStimulus(0, 0, 1);
    #1;
    checkOutput("tp_rst_data", 64'(out_data), 64'(32'h04030201));

    // Randomized traffic with varying fill rates, flushes, stalls and rare resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int phase;
      phase = (cyc / 200) % 3;
      if (phase == 0 && fifoQ.size() < 32 && $urandom_range(0, 3) != 0)
        fifoQ.push_back(DSIZE'($urandom));
      else if (phase == 1 && fifoQ.size() < 32 && $urandom_range(0, 24) == 0)
        fifoQ.push_back(DSIZE'($urandom));
      if ($urandom_range(0, 699) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 9) < 7);
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_packer.md
# async_fifo_rd_packer

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. It pops DSIZE-bit words whenever the FIFO is not empty and packs PACK consecutive words into one wide beat. Each beat is presented on a valid/ready output stream with a byte-lane keep mask. Partial beats are emitted on an explicit flush or after an idle timeout, so trailing data never strands in the packer.

## Interface
- DSIZE, 8, FIFO data width (matches FIFO DSIZE)
- PACK, 4, FIFO words per output beat; legal range 2..16
- TIMEOUT, 15, idle cycles before a partial beat is emitted; 0 disables the timeout

- rclk  in  1  read-domain clock; single clock
- rrst_n  in  1  reset; asynchronous, active-low
- rempty  in  1  FIFO empty flag
- rdata  in  DSIZE  FIFO read data; valid combinationally whenever rempty=0
- rinc  out  1  FIFO pop strobe
- flush  in  1  single-cycle request to emit any partial beat
- out_ready  in  1  downstream accept
- out_valid  out  1  beat valid
- out_data  out  DSIZE*PACK  packed beat; lane 0 = first word popped, in the LSBs
- out_keep  out  PACK  lane-valid mask
- out_last  out  1  beat closed by a flush

## Operation
- The accumulator holds lanes [PACK-1:0], a lane count cnt (0..PACK), and an idle counter.
- The output register holds one beat: out_valid, out_data, out_keep, out_last.
- Pop rule: rinc = !rempty && (cnt < PACK). On a pop, rdata is written to lane cnt and cnt increments.
- Close conditions (evaluated after this cycle's pop):
  - cnt reaches PACK;
  - flush, or a pending flush, with cnt>0;
  - timeout fires with cnt>0.
- Transfer: a closed beat moves to the output register when the register is empty or is draining this cycle (out_valid && out_ready). On transfer, cnt goes to 0 and the idle counter clears.
- Blocked close: if the output register is occupied and not draining, the beat stays in the accumulator. A full accumulator then holds rinc=0.
- out_keep = (1<<cnt)-1 at the moment of transfer. Unused lanes are zero.
- Flush handling:
  - A flush that cannot transfer is latched as pending and cleared when its beat transfers.
  - A flush with cnt==0 and no pop in that cycle is ignored.
- Idle counter: counts cycles with cnt>0 and no pop. It clears on any pop or transfer. The timeout fires when the counter equals TIMEOUT-1 in a cycle with no pop.
- out_last=1 only for beats closed by a flush, including a flush that coincides with cnt reaching PACK.
- Output register: loads on transfer; clears out_valid on a handshake with no new transfer.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, cnt=0, pending flush=0, idle=0. rinc=0 while rrst_n=0.
- Latency: the pop that completes a beat in cycle k gives out_valid=1 in cycle k+1, provided the transfer is not blocked.
- Throughput: one pop per cycle is sustained while out_ready=1 (the output register drains while the next beat fills).
- Hold rule: out_data, out_keep and out_last stay stable while out_valid && !out_ready.
- Pop and flush in the same cycle: the popped word is included in the flushed beat.
- Reset mid-operation: partial accumulator contents and any held beat are discarded. Popped FIFO data is lost (by design).
- Width rules:
  - cnt is $clog2(PACK+1) bits.
  - idle counter is $clog2(TIMEOUT+1) bits and saturates.

## Structure
- The shared package async_fifo_pkg holds:
  - default DSIZE, PACK and TIMEOUT constants;
  - the keep-mask function.
- Natural sub-module: packer_out_reg, the one-entry valid/ready holding register for data, keep and last.
- The top of this block is the accumulator, the counters and the pop/close control.

## Test plan
- PACK=4, rempty=0 with words 0x11,0x22,0x33,0x44, out_ready=1 -> rinc high for 4 cycles; next cycle out_data=0x44332211, keep=4'b1111, last=0.
- Push 2 words, then pulse flush -> one beat out_data=0x00002211, keep=4'b0011, last=1.
- Push 3 words, then rempty=1, TIMEOUT=15 -> beat with keep=4'b0111 and last=0 emitted 15 cycles after the last pop.
- out_ready=0 with 12 words available -> 2 beats are accepted (output register plus accumulator), then rinc=0. Raise out_ready -> all 3 beats delivered in order with no loss.
- Pop coinciding with flush at cnt=3 -> beat keep=4'b1111, last=1.
- Assert rrst_n=0 with cnt=2 and out_valid=1 -> all outputs zero immediately. The next beat after reset starts at lane 0.
